// File: rtl/cbb_rr_mux_pipe.sv
// N-channel round-robin mux with optional packet lock, feeding a 2-entry output FIFO.
// in_ready depends only on registered state and in_valid, never on out_ready.
module cbb_rr_mux_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned N        = 4,
  parameter bit          LOCK_PKT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [WIDTH*N-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [N-1:0]       out_sel
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]    ptr_q, lock_ch_q;
  logic             lock_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             wr_q, rd_q;
  logic [WIDTH-1:0] data_q [2];
  logic             last_q [2];
  logic [N-1:0]     sel_q  [2];

  logic [N-1:0]     grant;
  logic [PW-1:0]    gidx, cand, ptr_nxt;
  logic             gvalid, push, pop, plast;
  logic [WIDTH-1:0] pdata;

  // Channel index base+off, wrapped modulo N (N need not be a power of two).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  always_comb begin
    grant  = '0;
    gidx   = '0;
    gvalid = 1'b0;
    cand   = '0;
    if (lock_q) begin
      gidx   = lock_ch_q;
      gvalid = in_valid[lock_ch_q];
    end else begin
      // Scan from farthest to nearest so the channel closest to ptr wins.
      for (int unsigned k = N; k > 0; k--) begin
        cand = wrap_add(ptr_q, k - 1);
        if (in_valid[cand]) begin
          gidx   = cand;
          gvalid = 1'b1;
        end
      end
    end
    if (gvalid) grant[gidx] = 1'b1;
  end

  always_comb begin
    pdata = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) pdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign plast   = in_last[gidx];
  assign ptr_nxt = wrap_add(gidx, 1);

  // rst_n gating keeps in_ready low while the block is held in reset.
  assign in_ready = grant & {N{(cnt_q != 2'd2) & rst_n}};
  assign push     = gvalid & (cnt_q != 2'd2) & rst_n;
  assign pop      = (cnt_q != 2'd0) & out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      cnt_q     <= 2'd0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      sel_q[0]  <= '0;
      sel_q[1]  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (pop) rd_q <= ~rd_q;
      if (push) begin
        wr_q         <= ~wr_q;
        data_q[wr_q] <= pdata;
        last_q[wr_q] <= plast;
        sel_q[wr_q]  <= grant;
        if (LOCK_PKT && !plast) begin
          lock_q    <= 1'b1;
          lock_ch_q <= gidx;
        end else begin
          lock_q <= 1'b0;
          ptr_q  <= ptr_nxt;
        end
      end
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = data_q[rd_q];
  assign out_last  = last_q[rd_q];
  assign out_sel   = sel_q[rd_q];

endmodule

// File: tb/tb_cbb_rr_mux_pipe.sv
// Bench for cbb_rr_mux_pipe: vector tables, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_cbb_rr_mux_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, packet lock enabled.
  logic [3:0]  a_in_valid, a_in_ready, a_in_last, a_out_sel;
  logic [31:0] a_in_data;
  logic        a_out_valid, a_out_ready, a_out_last;
  logic [7:0]  a_out_data;

  // Instance B: N=3, re-arbitrate every beat.
  logic [2:0]  b_in_valid, b_in_ready, b_in_last, b_out_sel;
  logic [23:0] b_in_data;
  logic        b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_out_data;

  cbb_rr_mux_pipe #(.WIDTH(8), .N(4), .LOCK_PKT(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last),
    .out_sel(a_out_sel)
  );

  cbb_rr_mux_pipe #(.WIDTH(8), .N(3), .LOCK_PKT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
    .out_sel(b_out_sel)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    a_in_valid = '0; a_in_last = '0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = '0; b_in_last = '0; b_in_data = '0; b_out_ready = 1'b0;
  endtask

  // Hold reset with random inputs, then release it between clock edges.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      a_in_valid = 4'($urandom); a_in_last = 4'($urandom); a_in_data = $urandom;
      a_out_ready = 1'($urandom);
      b_in_valid = 3'($urandom); b_in_last = 3'($urandom); b_in_data = 24'($urandom);
      b_out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_in_ready", 32'(a_in_ready), 32'd0);
      chk("rst_out_sel", 32'(a_out_sel), 32'd0);
      chk("rst_b_in_ready", 32'(b_in_ready), 32'd0);
      next_cycle();
    end
    zero_inputs();
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_out_valid", 32'(a_out_valid), 32'd0);
    next_cycle();
    chk("rel_out_valid_next", 32'(a_out_valid), 32'd0);
  endtask

  typedef struct {
    bit         rs;     // reset before applying this row
    logic [3:0] v;
    logic [3:0] l;
    logic       ord;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [3:0] e_sel;
  } vec_t;

  vec_t tbl[19];

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [3:0] s;
  } beat_t;

  beat_t      mq[$];
  logic [7:0] got[$];

  initial begin
    zero_inputs();

    // Round-robin with single-beat packets, then packet lock, then lock stall.
    tbl[0]  = '{1, 4'b1111, 4'b1111, 1, 4'b0001, 0, 4'b0000};
    tbl[1]  = '{0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 4'b0001};
    tbl[2]  = '{0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 4'b0010};
    tbl[3]  = '{0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 4'b0100};
    tbl[4]  = '{0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 4'b1000};
    tbl[5]  = '{0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 4'b0001};
    tbl[6]  = '{1, 4'b0110, 4'b0100, 1, 4'b0010, 0, 4'b0000};
    tbl[7]  = '{0, 4'b0110, 4'b0100, 1, 4'b0010, 1, 4'b0010};
    tbl[8]  = '{0, 4'b0110, 4'b0110, 1, 4'b0010, 1, 4'b0010};
    tbl[9]  = '{0, 4'b0110, 4'b0110, 1, 4'b0100, 1, 4'b0010};
    tbl[10] = '{0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 4'b0100};
    tbl[11] = '{0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 4'b0000};
    tbl[12] = '{1, 4'b0110, 4'b0100, 1, 4'b0010, 0, 4'b0000};
    tbl[13] = '{0, 4'b0100, 4'b0100, 1, 4'b0000, 1, 4'b0010};
    tbl[14] = '{0, 4'b0100, 4'b0100, 1, 4'b0000, 0, 4'b0000};
    tbl[15] = '{0, 4'b0110, 4'b0100, 1, 4'b0010, 0, 4'b0000};
    tbl[16] = '{0, 4'b0110, 4'b0110, 1, 4'b0010, 1, 4'b0010};
    tbl[17] = '{0, 4'b0110, 4'b0110, 1, 4'b0100, 1, 4'b0010};
    tbl[18] = '{0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 4'b0100};

    #1;
    for (int r = 0; r < 19; r++) begin
      if (tbl[r].rs) do_reset();
      a_in_valid  = tbl[r].v;
      a_in_last   = tbl[r].l;
      a_in_data   = 32'h4433_2211;
      a_out_ready = tbl[r].ord;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", r), 32'(a_in_ready), 32'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_out_valid", r), 32'(a_out_valid), 32'(tbl[r].e_ov));
      if (tbl[r].e_ov) chk($sformatf("tbl%0d_out_sel", r), 32'(a_out_sel), 32'(tbl[r].e_sel));
      next_cycle();
    end

    // Backpressure: ch0 streams 0x11,0x22,0x33 into a stalled output.
    begin
      logic [7:0] vals [3];
      logic [9:0] er;
      int idx;
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      er = 10'b00_0100_0011;
      idx = 0;
      do_reset();
      got.delete();
      for (int c = 0; c < 10; c++) begin
        a_out_ready = (c >= 5);
        a_in_valid  = (idx < 3) ? 4'b0001 : 4'b0000;
        a_in_last   = 4'b0001;
        a_in_data   = (idx < 3) ? {24'h0, vals[idx]} : 32'h0;
        @(negedge clk);
        chk($sformatf("bp%0d_in_ready", c), 32'(a_in_ready[0]), 32'(er[c]));
        if (c >= 2 && c <= 4) chk("bp_hold_data", 32'(a_out_data), 32'h11);
        if (a_out_valid && a_out_ready) got.push_back(a_out_data);
        if (a_in_valid[0] && a_in_ready[0]) idx++;
        next_cycle();
      end
      chk("bp_accepted", 32'(idx), 32'd3);
      chk("bp_out_count", 32'(got.size()), 32'd3);
      for (int i = 0; i < 3 && i < got.size(); i++)
        chk($sformatf("bp_out%0d", i), 32'(got[i]), 32'(vals[i]));
    end

    // N=3 wrap: move ptr to 2 via ch1, then 3'b011 must give ch0, ch1, ch0.
    begin
      logic [2:0] bv [4];
      logic [2:0] br [4];
      bv[0] = 3'b010; bv[1] = 3'b011; bv[2] = 3'b011; bv[3] = 3'b011;
      br[0] = 3'b010; br[1] = 3'b001; br[2] = 3'b010; br[3] = 3'b001;
      do_reset();
      for (int c = 0; c < 5; c++) begin
        b_out_ready = 1'b1;
        b_in_last   = 3'b000;
        b_in_data   = 24'h030201;
        b_in_valid  = (c < 4) ? bv[c] : 3'b000;
        @(negedge clk);
        if (c < 4) chk($sformatf("wrap%0d_in_ready", c), 32'(b_in_ready), 32'(br[c]));
        if (c > 0) chk($sformatf("wrap%0d_out_sel", c), 32'(b_out_sel), 32'(br[c-1]));
        next_cycle();
      end
      b_in_valid = '0;
    end

    // Reset mid-packet with a full FIFO, then ch3 alone must be granted at once.
    do_reset();
    a_out_ready = 1'b0;
    a_in_valid  = 4'b0010;
    a_in_last   = 4'b0000;
    a_in_data   = 32'h0000_5500;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("mid_in_ready", 32'(a_in_ready), 32'b0010);
      next_cycle();
    end
    @(negedge clk);
    chk("mid_full_ready", 32'(a_in_ready), 32'd0);
    chk("mid_full_valid", 32'(a_out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
    next_cycle();
    a_in_valid = 4'b1000;
    a_in_last  = 4'b1000;
    a_in_data  = 32'h7700_0000;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("mid_rel_in_ready", 32'(a_in_ready), 32'b1000);
    chk("mid_rel_out_valid", 32'(a_out_valid), 32'd0);
    next_cycle();
    a_in_valid = 4'b0000;
    @(negedge clk);
    chk("mid_ch3_valid", 32'(a_out_valid), 32'd1);
    chk("mid_ch3_sel", 32'(a_out_sel), 32'b1000);
    chk("mid_ch3_data", 32'(a_out_data), 32'h77);
    next_cycle();

    // Random run against the reference model.
    begin
      int mptr;
      bit mlock;
      int mlch;
      int g;
      logic [3:0] erdy;
      beat_t b;
      do_reset();
      mq.delete();
      mptr = 0; mlock = 0; mlch = 0;
      for (int c = 0; c < 1500; c++) begin
        a_in_valid  = 4'($urandom);
        a_in_last   = 4'($urandom);
        a_in_data   = $urandom;
        a_out_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);
        g = -1;
        if (mlock) begin
          if (a_in_valid[mlch]) g = mlch;
        end else begin
          for (int k = 3; k >= 0; k--)
            if (a_in_valid[(mptr + k) % 4]) g = (mptr + k) % 4;
        end
        erdy = (g >= 0 && mq.size() < 2) ? 4'(1 << g) : 4'b0000;
        chk("rnd_in_ready", 32'(a_in_ready), 32'(erdy));
        chk("rnd_out_valid", 32'(a_out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
          chk("rnd_out_data", 32'(a_out_data), 32'(mq[0].d));
          chk("rnd_out_last", 32'(a_out_last), 32'(mq[0].l));
          chk("rnd_out_sel", 32'(a_out_sel), 32'(mq[0].s));
          if (a_out_ready) void'(mq.pop_front());
        end
        if (erdy != 4'b0000) begin
          b.d = a_in_data[g*8 +: 8];
          b.l = a_in_last[g];
          b.s = erdy;
          mq.push_back(b);
          if (b.l) begin
            mlock = 0;
            mptr = (g + 1) % 4;
          end else begin
            mlock = 1;
            mlch = g;
          end
        end
        next_cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
